// File: rtl/ddr3_ui_pkg.sv
// Shared constants and FSM encoding for the DDR3 user-interface responder.
// Imported by the responder top and its backing-store RAM.
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int DQ_WIDTH_DEF = 16;
    localparam int BEAT_W       = 8 * DQ_WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD
    } state_t;

endpackage

// File: rtl/ddr3_ui_responder_if.sv
// Command/data bus between a DDR3 user-side initiator (master) and the
// memory side it talks to (slave).
interface ddr3_ui_responder_if #(
    parameter int DQ_WIDTH   = 16,
    parameter int ADDR_WIDTH = 22
);
    logic                    init_done;
    logic [2:0]              cmd;
    logic                    cmd_en;
    logic                    cmd_rdy;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [5:0]              ddr3_burst_number;
    logic                    ddr3_wr_rdy;
    logic                    ddr3_wren;
    logic [8*DQ_WIDTH-1:0]   ddr3_wr_data;
    logic                    ddr3_wr_end;
    logic                    ddr3_rd_valid;
    logic [8*DQ_WIDTH-1:0]   ddr3_rd_data;
    logic                    proto_err;

    modport master (
        input  init_done, cmd_rdy, ddr3_wr_rdy, ddr3_rd_valid, ddr3_rd_data, proto_err,
        output cmd, cmd_en, addr, ddr3_burst_number, ddr3_wren, ddr3_wr_data, ddr3_wr_end
    );

    modport slave (
        output init_done, cmd_rdy, ddr3_wr_rdy, ddr3_rd_valid, ddr3_rd_data, proto_err,
        input  cmd, cmd_en, addr, ddr3_burst_number, ddr3_wren, ddr3_wr_data, ddr3_wr_end
    );

endinterface

// File: rtl/ddr3_ui_bram.sv
// Simple dual-port backing store, one write port and one registered read
// port, written in the shape block-RAM inference expects.
module ddr3_ui_bram
    import ddr3_ui_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = BEAT_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset; contents survive rst_n and a reset loop would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddr3_ui_responder.sv
// Stand-in for the DDR3 IP + PHY: accepts user-side write/read bursts, keeps
// them in block RAM and flags initiator protocol violations.
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int DQ_WIDTH    = 16,
    parameter int ADDR_WIDTH  = 22,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 64,
    parameter int RD_LAT      = 4
) (
    input  logic               clk_ref,
    input  logic               rst_n,
    ddr3_ui_responder_if.slave ui
);

    localparam int             BW       = 8 * DQ_WIDTH;
    localparam int             IW       = $clog2(INIT_CYCLES + 1);
    localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam int             LAT_WAIT = (RD_LAT > 2) ? RD_LAT - 3 : 0;
    localparam logic [7:0]     LAT_INIT = 8'(LAT_WAIT);

    state_t            state, state_nxt;
    logic [IW-1:0]     init_cnt;
    logic [7:0]        lat_cnt;
    logic [MEM_AW-1:0] idx;
    logic [5:0]        beats_left;
    logic              rd_drain;
    logic              rd_issue_q;
    logic              accept;
    logic              mem_we;
    logic              mem_re;
    logic              err_set;
    logic              wr_commit;
    logic [BW-1:0]     mem_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ui.addr[ADDR_WIDTH-1:MEM_AW+3], ui.addr[2:0]};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = ui.cmd_en && ui.cmd_rdy;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        err_set   = 1'b0;

        if (ui.cmd_en && !ui.cmd_rdy) err_set = 1'b1;
        if (state != ST_WR && (ui.ddr3_wren || ui.ddr3_wr_end)) err_set = 1'b1;

        case (state)
            ST_INIT: if (init_cnt == INIT_LAST) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    if (ui.cmd == CMD_WR)      state_nxt = ST_WR;
                    else if (ui.cmd == CMD_RD) state_nxt = (RD_LAT > 2) ? ST_RD_WAIT : ST_RD;
                    else                       err_set   = 1'b1;
                end
            end
            ST_WR: begin
                if (ui.ddr3_wren) begin
                    mem_we = 1'b1;
                    if (beats_left == '0) begin
                        state_nxt = ST_IDLE;
                        if (!ui.ddr3_wr_end) err_set = 1'b1;
                    end else if (ui.ddr3_wr_end) begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: if (lat_cnt == '0) state_nxt = ST_RD;
            // One extra RD cycle after the last issue lets the read pipe drain
            // before cmd_rdy can return.
            ST_RD: begin
                if (rd_drain) state_nxt = ST_IDLE;
                else          mem_re    = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign wr_commit = mem_we && rst_n;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            init_cnt         <= '0;
            lat_cnt          <= '0;
            idx              <= '0;
            beats_left       <= '0;
            rd_drain         <= 1'b0;
            rd_issue_q       <= 1'b0;
            ui.init_done     <= 1'b0;
            ui.cmd_rdy       <= 1'b0;
            ui.ddr3_wr_rdy   <= 1'b0;
            ui.ddr3_rd_valid <= 1'b0;
            ui.ddr3_rd_data  <= '0;
            ui.proto_err     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_INIT && init_cnt != INIT_LAST) init_cnt <= init_cnt + 1'b1;
            if (state == ST_INIT && state_nxt == ST_IDLE)  ui.init_done <= 1'b1;

            ui.cmd_rdy     <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
            ui.ddr3_wr_rdy <= (state_nxt == ST_WR);

            if (accept) begin
                idx        <= ui.addr[MEM_AW+2:3];
                beats_left <= ui.ddr3_burst_number;
                lat_cnt    <= LAT_INIT;
                rd_drain   <= 1'b0;
            end else if (mem_we || mem_re) begin
                idx <= idx + 1'b1;
                if (beats_left != '0) beats_left <= beats_left - 1'b1;
                else if (mem_re)      rd_drain   <= 1'b1;
            end

            if (state == ST_RD_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;

            rd_issue_q       <= mem_re;
            ui.ddr3_rd_valid <= rd_issue_q;
            if (rd_issue_q) ui.ddr3_rd_data <= mem_rdata;

            if (err_set) ui.proto_err <= 1'b1;
        end
    end

    ddr3_ui_bram #(
        .AW (MEM_AW),
        .DW (BW)
    ) u_bram (
        .clk   (clk_ref),
        .we    (wr_commit),
        .waddr (idx),
        .wdata (ui.ddr3_wr_data),
        .re    (mem_re),
        .raddr (idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Directed bench for ddr3_ui_responder: a cycle-indexed schedule of expected
// read beats plus a shadow memory, checked every cycle at the falling edge.
module tb_ddr3_ui_responder;
    import ddr3_ui_pkg::*;

    localparam int DQ_WIDTH    = 16;
    localparam int ADDR_WIDTH  = 22;
    localparam int MEM_AW      = 10;
    localparam int INIT_CYCLES = 64;
    localparam int RD_LAT      = 4;
    localparam int BW          = 8 * DQ_WIDTH;
    localparam int DEPTH       = 1 << MEM_AW;
    localparam int NEVER       = 32'h7fff_ffff;

    logic clk_ref = 1'b0;
    logic rst_n   = 1'b0;

    ddr3_ui_responder_if #(.DQ_WIDTH(DQ_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) ui ();

    ddr3_ui_responder #(
        .DQ_WIDTH    (DQ_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MEM_AW      (MEM_AW),
        .INIT_CYCLES (INIT_CYCLES),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .ui      (ui)
    );

    always #5 clk_ref = ~clk_ref;

    int errors = 0;
    int checks = 0;

    // Model: shadow memory, expected read beats keyed by rising-edge number,
    // and the first edges at which proto_err / init_done must be high.
    logic [BW-1:0] model_mem [DEPTH];
    bit            exp_v [int];
    logic [BW-1:0] exp_d [int];
    int            err_edge  = NEVER;
    int            init_edge = NEVER;
    logic [BW-1:0] rd_log [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Rising edges seen so far (posedges at 5, 15, 25, ...).
    function automatic int edges_now();
        return int'(($time + 5) / 10);
    endfunction

    function automatic logic [BW-1:0] pattern(input int seed);
        return {8{16'hD000 + 16'(seed)}};
    endfunction

    function automatic void note_err(input int e);
        if (e < err_edge) err_edge = e;
    endfunction

    initial begin : compare
        int cyc;
        forever begin
            @(negedge clk_ref);
            cyc = edges_now();
            check("rd_valid", ui.ddr3_rd_valid, exp_v.exists(cyc));
            if (exp_v.exists(cyc)) begin
                check("rd_data", ui.ddr3_rd_data, exp_d[cyc]);
                rd_log.push_back(ui.ddr3_rd_data);
            end
            check("proto_err", ui.proto_err, cyc >= err_edge);
            check("init_done", ui.init_done, cyc >= init_edge);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic clear_inputs();
        ui.cmd               = '0;
        ui.cmd_en            = 1'b0;
        ui.addr              = '0;
        ui.ddr3_burst_number = '0;
        ui.ddr3_wren         = 1'b0;
        ui.ddr3_wr_data      = '0;
        ui.ddr3_wr_end       = 1'b0;
    endtask

    task automatic release_and_init(input string tag);
        int low;
        low       = 0;
        rst_n     = 1'b1;
        init_edge = edges_now() + INIT_CYCLES;
        while (ui.init_done !== 1'b1 && low < 200) begin
            low++;
            step();
        end
        check({tag, "_init_low_cycles"}, low, 64);
        check({tag, "_cmd_rdy_with_init"}, ui.cmd_rdy, 0);
        step();
        check({tag, "_cmd_rdy_after_init"}, ui.cmd_rdy, 1);
    endtask

    task automatic do_reset(input string tag);
        int e;
        int keys [$];
        rst_n = 1'b0;
        step();
        e = edges_now();
        foreach (exp_v[k]) if (k >= e) keys.push_back(k);
        foreach (keys[j]) begin
            exp_v.delete(keys[j]);
            exp_d.delete(keys[j]);
        end
        err_edge  = NEVER;
        init_edge = NEVER;
        clear_inputs();
        check({tag, "_rd_valid_in_reset"}, ui.ddr3_rd_valid, 0);
        step();
        release_and_init(tag);
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [ADDR_WIDTH-1:0] a,
                            input logic [5:0] bn, output int acc);
        int n;
        n = 0;
        while (ui.cmd_rdy !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("cmd_rdy_wait", ui.cmd_rdy, 1);
        ui.cmd               = c;
        ui.addr              = a;
        ui.ddr3_burst_number = bn;
        ui.cmd_en            = 1'b1;
        acc                  = edges_now() + 1;
        step();
        ui.cmd_en = 1'b0;
        if (c != CMD_WR && c != CMD_RD) note_err(acc);
    endtask

    // end_beat: beat index carrying wr_end (-1 for none).
    task automatic write_burst(input logic [ADDR_WIDTH-1:0] a, input int bn,
                               input int seed, input int end_beat, input string tag);
        int acc;
        int idx;
        int beat_edge;
        idx = int'(a >> 3) % DEPTH;
        send_cmd(CMD_WR, a, 6'(bn), acc);
        for (int i = 0; i <= bn; i++) begin
            check({tag, "_wr_rdy"}, ui.ddr3_wr_rdy, 1);
            ui.ddr3_wren    = 1'b1;
            ui.ddr3_wr_data = pattern(seed + i);
            ui.ddr3_wr_end  = (i == end_beat);
            model_mem[(idx + i) % DEPTH] = pattern(seed + i);
            beat_edge = edges_now() + 1;
            step();
            if (i == end_beat || i == bn) begin
                if (i != bn || end_beat != bn) note_err(beat_edge);
                break;
            end
        end
        ui.ddr3_wren   = 1'b0;
        ui.ddr3_wr_end = 1'b0;
        check({tag, "_wr_rdy_after"}, ui.ddr3_wr_rdy, 0);
        check({tag, "_cmd_rdy_low"}, ui.cmd_rdy, 0);
        step();
        check({tag, "_cmd_rdy_back"}, ui.cmd_rdy, 1);
    endtask

    task automatic read_burst(input logic [ADDR_WIDTH-1:0] a, input int bn,
                              input bit inject, input string tag);
        int acc;
        int idx;
        idx = int'(a >> 3) % DEPTH;
        rd_log.delete();
        send_cmd(CMD_RD, a, 6'(bn), acc);
        for (int i = 0; i <= bn; i++) begin
            exp_v[acc + RD_LAT + i] = 1'b1;
            exp_d[acc + RD_LAT + i] = model_mem[(idx + i) % DEPTH];
        end
        if (inject) begin
            ui.cmd    = CMD_WR;
            ui.cmd_en = 1'b1;
            note_err(edges_now() + 1);
            step();
            ui.cmd_en = 1'b0;
            check({tag, "_busy_cmd_ignored"}, ui.ddr3_wr_rdy, 0);
        end
        while (edges_now() < acc + 3) step();
        check({tag, "_valid_before_lat"}, ui.ddr3_rd_valid, 0);
        step();
        check({tag, "_valid_at_lat"}, ui.ddr3_rd_valid, 1);
        while (edges_now() < acc + RD_LAT + bn) step();
        check({tag, "_cmd_rdy_last_beat"}, ui.cmd_rdy, 0);
        step();
        check({tag, "_valid_after_last"}, ui.ddr3_rd_valid, 0);
        check({tag, "_cmd_rdy_after_last"}, ui.cmd_rdy, 1);
        check({tag, "_beats"}, rd_log.size(), bn + 1);
    endtask

    initial begin : main
        int acc;
        clear_inputs();
        step();
        step();
        release_and_init("por");

        // Basic write then read-back at index 2..5.
        write_burst(22'h000010, 3, 'h00, 3, "wr_basic");
        read_burst(22'h000010, 3, 1'b0, "rd_basic");
        check("rd_basic_beat0_lit", rd_log[0], 128'hD000_D000_D000_D000_D000_D000_D000_D000);
        check("rd_basic_beat3_lit", rd_log[3], 128'hD003_D003_D003_D003_D003_D003_D003_D003);

        // Wrap from index 1023 to 0, issued through an aliased address.
        write_burst(22'h3FFFF8, 1, 'h40, 1, "wr_wrap");
        read_burst(22'h001FF8, 1, 1'b0, "rd_wrap");
        check("rd_wrap_beat1_lit", rd_log[1], 128'hD041_D041_D041_D041_D041_D041_D041_D041);

        // Early wr_end on the second beat: only the first two beats change.
        write_burst(22'h000100, 3, 'h50, 3, "wr_fill");
        write_burst(22'h000100, 3, 'h60, 1, "wr_early");
        read_burst(22'h000100, 3, 1'b0, "rd_early");
        check("rd_early_beat1_lit", rd_log[1], 128'hD061_D061_D061_D061_D061_D061_D061_D061);
        check("rd_early_beat2_lit", rd_log[2], 128'hD052_D052_D052_D052_D052_D052_D052_D052);
        do_reset("rst_a");

        // Stray write beat in IDLE: flagged, memory and state untouched.
        ui.ddr3_wren    = 1'b1;
        ui.ddr3_wr_data = pattern('h99);
        note_err(edges_now() + 1);
        step();
        ui.ddr3_wren = 1'b0;
        check("stray_wren_cmd_rdy", ui.cmd_rdy, 1);
        read_burst(22'h000010, 3, 1'b0, "rd_after_stray");
        do_reset("rst_b");

        // Illegal opcode: flagged, stays in IDLE.
        send_cmd(3'b010, 22'h000010, 6'd0, acc);
        check("illegal_cmd_rdy", ui.cmd_rdy, 1);
        check("illegal_wr_rdy", ui.ddr3_wr_rdy, 0);
        read_burst(22'h000100, 1, 1'b0, "rd_after_illegal");
        do_reset("rst_c");

        // Command while busy reading: flagged and ignored.
        read_burst(22'h001FF8, 1, 1'b1, "rd_busy");

        // Reset while beat 2 of an 8-beat read is on the bus.
        write_burst(22'h000200, 7, 'h70, 7, "wr_long");
        rd_log.delete();
        send_cmd(CMD_RD, 22'h000200, 6'd7, acc);
        for (int i = 0; i <= 7; i++) begin
            exp_v[acc + RD_LAT + i] = 1'b1;
            exp_d[acc + RD_LAT + i] = model_mem[(64 + i) % DEPTH];
        end
        while (edges_now() < acc + RD_LAT + 2) step();
        check("abort_beat2_valid", ui.ddr3_rd_valid, 1);
        do_reset("rst_d");
        read_burst(22'h000200, 7, 1'b0, "rd_after_reset");
        check("rd_after_reset_beat5_lit", rd_log[5], 128'hD075_D075_D075_D075_D075_D075_D075_D075);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
